cla_add_sequencer: RTL

CLA_ADD_SEQUENCER -- requirements
Module: cla_add_sequencer

---
 rtl/cla_pkg.sv | 14 +
 rtl/cla_slice4.sv | 34 +++
 rtl/cla_add_sequencer.sv | 131 +++++++++++++
 3 files changed

// File: rtl/cla_pkg.sv
// Shared definitions for the slice-serial carry-lookahead adder.
//   state_e : sequencer states (IDLE, RUN, DONE)
//   SLICE_W : bits handled per RUN cycle by one cla_slice4
package cla_pkg;

   localparam int SLICE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/cla_slice4.sv
// 4-bit carry-lookahead adder slice with explicit generate/propagate terms.
// Ports:
//   a, b : 4-bit addends
//   ci   : carry in
//   s    : 4-bit sum
//   co   : carry out of bit 3
module cla_slice4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       ci,
   output logic [3:0] s,
   output logic       co
);

   logic [3:0] g;
   logic [3:0] p;
   logic [4:0] c;

   assign g = a & b;
   assign p = a ^ b;

   // every carry is a flat sum of products of g/p/ci, no ripple chain
   assign c[0] = ci;
   assign c[1] = g[0] | (p[0] & ci);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & ci);
   assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & ci);

   assign s  = p ^ c[3:0];
   assign co = c[4];

endmodule

// File: rtl/cla_add_sequencer.sv
// Slice-serial adder: one request is latched, then added 4 bits per cycle
// through a single reused cla_slice4, and the result is held until consumed.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid, in_ready  : request handshake (in_ready only in IDLE)
//   a, b, cin           : operands and carry in
//   out_valid, out_ready: result handshake (out_valid only in DONE)
//   sum, cout, ovf      : a+b+cin mod 2^WIDTH, MSB carry, signed overflow
//   busy                : not IDLE
//
// state | meaning
// IDLE  | waiting for a request, result outputs hold last values
// RUN   | adding slice cnt, one slice per cycle
// DONE  | result valid, held until out_ready
module cla_add_sequencer
   import cla_pkg::*;
#(
   parameter int WIDTH = 16   // multiple of 4, at least 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             busy
);

   localparam int NSLICE = WIDTH / SLICE_W;
   localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   localparam logic [1:0]    S_IDLE = IDLE;
   localparam logic [1:0]    S_RUN  = RUN;
   localparam logic [1:0]    S_DONE = DONE;
   localparam logic [CW-1:0] LAST   = CW'(NSLICE - 1);

   logic [1:0]         state;
   logic [CW-1:0]      cnt;
   logic               carry;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic [WIDTH-1:0]   sum_q;
   logic               cout_q;
   logic               ovf_q;

   logic [SLICE_W-1:0] sa;
   logic [SLICE_W-1:0] sb;
   logic [SLICE_W-1:0] ss;
   logic               sco;

   // operand slice selected by the counter
   always_comb begin
      sa = '0;
      sb = '0;
      for (int i = 0; i < NSLICE; i++) begin
         if (cnt == CW'(i)) begin
            sa = a_q[i*SLICE_W +: SLICE_W];
            sb = b_q[i*SLICE_W +: SLICE_W];
         end
      end
   end

   cla_slice4 u_slice (
      .a  (sa),
      .b  (sb),
      .ci (carry),
      .s  (ss),
      .co (sco)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= S_IDLE;
         cnt    <= '0;
         carry  <= 1'b0;
         a_q    <= '0;
         b_q    <= '0;
         sum_q  <= '0;
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  a_q   <= a;
                  b_q   <= b;
                  carry <= cin;
                  cnt   <= '0;
                  state <= S_RUN;
               end
            end
            S_RUN: begin
               for (int i = 0; i < NSLICE; i++) begin
                  if (cnt == CW'(i)) sum_q[i*SLICE_W +: SLICE_W] <= ss;
               end
               carry <= sco;
               if (cnt == LAST) begin
                  cout_q <= sco;
                  // ss[MSB] is the new sum MSB being written this cycle
                  ovf_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (ss[SLICE_W-1] != a_q[WIDTH-1]);
                  cnt    <= '0;
                  state  <= S_DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_DONE: begin
               if (out_ready) state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

   assign in_ready  = (state == S_IDLE);
   assign out_valid = (state == S_DONE);
   assign busy      = (state != S_IDLE);
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;

endmodule
